pmbus_write_decoder: RTL and testbench



---
 rtl/pmbus_write_decoder.sv | 172 +++++++++++++++++
 tb/tb_pmbus_write_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pmbus_write_decoder.sv
// PMBus write decoder: turns the SMBus PHY byte stream into register-bank write strobes.
// Optional trailing PEC byte checking is enabled by defining PMBUS_PEC_EN.
module pmbus_write_decoder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h40,
  parameter int         DATA_W     = 16
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              RX_START,
  input  logic              RX_VALID,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_STOP,
  output logic              REG_WRITE,
  output logic [7:0]        CMD_CODE,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              CMD_ERR,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_t;

  if (DATA_W != 16 || SLAVE_ADDR == 7'h00) begin : gParamCheck
    $error("pmbus_write_decoder: DATA_W must be 16 and SLAVE_ADDR must not be the general-call address");
  end

`ifdef PMBUS_PEC_EN
  localparam logic [2:0] PEC_BYTES = 3'd1;

  function automatic logic [7:0] crc8Update(input logic [7:0] crc, input logic [7:0] dataByte);
    logic [7:0] c;
    c = crc ^ dataByte;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Every transaction's CRC starts from the (write) address byte, which is fixed.
  localparam logic [7:0] ADDR_CRC = crc8Update(8'h00, {SLAVE_ADDR, 1'b0});

  logic [7:0] crc_q, crc_d;
`else
  localparam logic [2:0] PEC_BYTES = 3'd0;
`endif

  function automatic logic cmdSupported(input logic [7:0] code);
    case (code)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h21, 8'h40, 8'h44, 8'h60, 8'h64: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] cmdLength(input logic [7:0] code);
    case (code)
      8'h00, 8'h01, 8'h02:                   return 3'd1;
      8'h21, 8'h40, 8'h44, 8'h60, 8'h64:     return 3'd2;
      default:                               return 3'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  cmdCode_q, cmdCode_d;
  logic [15:0] data_q, data_d;
  logic        regWrite_q, regWrite_d;
  logic        cmdErr_q, cmdErr_d;
  logic [2:0]  expLen;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      count_q    <= '0;
      cmdCode_q  <= '0;
      data_q     <= '0;
      regWrite_q <= 1'b0;
      cmdErr_q   <= 1'b0;
`ifdef PMBUS_PEC_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cmdCode_q  <= cmdCode_d;
      data_q     <= data_d;
      regWrite_q <= regWrite_d;
      cmdErr_q   <= cmdErr_d;
`ifdef PMBUS_PEC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  // Within one cycle the byte is taken first, then STOP is judged, then START restarts.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cmdCode_d  = cmdCode_q;
    data_d     = data_q;
    regWrite_d = 1'b0;
    cmdErr_d   = 1'b0;
`ifdef PMBUS_PEC_EN
    crc_d      = crc_q;
`endif
    expLen     = cmdLength(cmdCode_q);

    case (state_q)
      IDLE: ;
      CMD: begin
        if (RX_VALID) begin
          cmdCode_d = RX_DATA;
          count_d   = '0;
          data_d    = '0;
`ifdef PMBUS_PEC_EN
          crc_d     = crc8Update(crc_q, RX_DATA);
`endif
          state_d   = cmdSupported(RX_DATA) ? DATA : DISCARD;
          if (RX_STOP) begin
            state_d = IDLE;
            if (cmdSupported(RX_DATA) && cmdLength(RX_DATA) == 3'd0) regWrite_d = 1'b1;
            else                                                      cmdErr_d   = 1'b1;
          end
        end else if (RX_STOP) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (RX_VALID) begin
          if (count_q < expLen) begin
            if (count_q == 3'd0) data_d[7:0]  = RX_DATA;
            else                 data_d[15:8] = RX_DATA;
          end
          count_d = count_q + 3'd1;
`ifdef PMBUS_PEC_EN
          crc_d   = crc8Update(crc_q, RX_DATA);
`endif
          if (count_d > expLen + PEC_BYTES) state_d = DISCARD;
        end
        if (RX_STOP) begin
          state_d = IDLE;
          if (count_d == expLen) regWrite_d = 1'b1;
`ifdef PMBUS_PEC_EN
          // Running the CRC over a correct PEC byte leaves a zero remainder.
          else if (count_d == expLen + 3'd1 && crc_d == 8'h00) regWrite_d = 1'b1;
`endif
          else cmdErr_d = 1'b1;
        end
      end
      DISCARD: begin
        if (RX_STOP) begin
          cmdErr_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (RX_START) begin
      state_d = CMD;
      count_d = '0;
`ifdef PMBUS_PEC_EN
      crc_d   = ADDR_CRC;
`endif
    end
  end

  assign REG_WRITE = regWrite_q;
  assign CMD_ERR   = cmdErr_q;
  assign CMD_CODE  = cmdCode_q;
  assign DATA_OUT  = data_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_pmbus_write_decoder.sv
// Self-checking bench for pmbus_write_decoder: directed transaction table plus corner-case sequences.
module tb_pmbus_write_decoder;

  logic        CLOCK;
  logic        RESET_N;
  logic        RX_START;
  logic        RX_VALID;
  logic [7:0]  RX_DATA;
  logic        RX_STOP;
  logic        REG_WRITE;
  logic [7:0]  CMD_CODE;
  logic [15:0] DATA_OUT;
  logic        CMD_ERR;
  logic        BUSY;

  int testCount = 0;
  int failCount = 0;
  int wrCount   = 0;
  int errCount  = 0;

  pmbus_write_decoder #(.SLAVE_ADDR(7'h40), .DATA_W(16)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .RX_START(RX_START), .RX_VALID(RX_VALID),
    .RX_DATA(RX_DATA), .RX_STOP(RX_STOP), .REG_WRITE(REG_WRITE), .CMD_CODE(CMD_CODE),
    .DATA_OUT(DATA_OUT), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Strobes are high for one full cycle, so each one is seen at exactly one falling edge.
  always @(negedge CLOCK) begin
    if (REG_WRITE) wrCount++;
    if (CMD_ERR)   errCount++;
  end

  typedef struct {
    string           name;
    int              nBytes;
    logic [0:4][7:0] bytes;
    bit              expWr;
    bit              expErr;
    logic [7:0]      expCmd;
    logic [15:0]     expData;
    bit              chkData;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data, input logic stop);
    RX_START = start;
    RX_VALID = valid;
    RX_DATA  = data;
    RX_STOP  = stop;
    @(posedge CLOCK);
    #1;
    RX_START = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    RX_STOP  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  initial begin
    int wr0;
    int er0;

    RESET_N  = 1'b0;
    RX_START = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    RX_STOP  = 1'b0;

    vecs.push_back('{"page",     2, 40'h00_03_00_00_00, 1, 0, 8'h00, 16'h0003, 1});
    vecs.push_back('{"vout",     3, 40'h21_34_12_00_00, 1, 0, 8'h21, 16'h1234, 1});
    vecs.push_back('{"clrflt",   1, 40'h03_00_00_00_00, 1, 0, 8'h03, 16'h0000, 1});
    vecs.push_back('{"short",    2, 40'h21_34_00_00_00, 0, 1, 8'h21, 16'h0000, 0});
    vecs.push_back('{"long",     4, 40'h01_80_00_00_00, 0, 1, 8'h01, 16'h0000, 0});
    vecs.push_back('{"unsup",    2, 40'h7F_00_00_00_00, 0, 1, 8'h7F, 16'h0000, 0});
    vecs.push_back('{"ovlim",    3, 40'h40_CD_AB_00_00, 1, 0, 8'h40, 16'hABCD, 1});
    vecs.push_back('{"onoff",    2, 40'h02_05_00_00_00, 1, 0, 8'h02, 16'h0005, 1});
`ifdef PMBUS_PEC_EN
    vecs.push_back('{"pecgood",  3, 40'h01_80_97_00_00, 1, 0, 8'h01, 16'h0080, 1});
`else
    vecs.push_back('{"pecgood",  3, 40'h01_80_97_00_00, 0, 1, 8'h01, 16'h0000, 0});
`endif
    vecs.push_back('{"pecbad",   3, 40'h01_80_96_00_00, 0, 1, 8'h01, 16'h0000, 0});
    vecs.push_back('{"toolong",  5, 40'h64_01_02_03_04, 0, 1, 8'h64, 16'h0000, 0});
    vecs.push_back('{"nodata",   1, 40'h00_00_00_00_00, 0, 1, 8'h00, 16'h0000, 0});
    vecs.push_back('{"quick",    0, 40'h00_00_00_00_00, 0, 0, 8'h00, 16'h0000, 0});

    repeat (2) @(posedge CLOCK);
    #1;
    checkOutput("rst_regwrite", {15'd0, REG_WRITE}, 16'h0000);
    checkOutput("rst_cmdcode",  {8'd0, CMD_CODE},   16'h0000);
    checkOutput("rst_data",     DATA_OUT,           16'h0000);
    checkOutput("rst_cmderr",   {15'd0, CMD_ERR},   16'h0000);
    checkOutput("rst_busy",     {15'd0, BUSY},      16'h0000);
    RESET_N = 1'b1;
    applyStimulus(0, 0, 8'h00, 0);

    // Directed table: START, bytes, STOP, then check the strobe cycle and the idle cycle after it.
    for (int i = 0; i < vecs.size(); i++) begin
      wr0 = wrCount;
      er0 = errCount;
      applyStimulus(1, 0, 8'h00, 0);
      for (int b = 0; b < vecs[i].nBytes; b++) applyStimulus(0, 1, vecs[i].bytes[b], 0);
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput({vecs[i].name, "_regwrite"}, {15'd0, REG_WRITE}, {15'd0, vecs[i].expWr});
      checkOutput({vecs[i].name, "_cmderr"},   {15'd0, CMD_ERR},   {15'd0, vecs[i].expErr});
      checkOutput({vecs[i].name, "_cmdcode"},  {8'd0, CMD_CODE},   {8'd0, vecs[i].expCmd});
      if (vecs[i].chkData) checkOutput({vecs[i].name, "_data"}, DATA_OUT, vecs[i].expData);
      applyStimulus(0, 0, 8'h00, 0);
      checkOutput({vecs[i].name, "_busy"},     {15'd0, BUSY},      16'h0000);
      checkOutput({vecs[i].name, "_nwrites"},  16'(wrCount - wr0), {15'd0, vecs[i].expWr});
      checkOutput({vecs[i].name, "_nerrors"},  16'(errCount - er0), {15'd0, vecs[i].expErr});
    end

    // Repeated START aborts the pending write silently and keeps the command code.
    wr0 = wrCount;
    er0 = errCount;
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("rs_busy_high", {15'd0, BUSY}, 16'h0001);
    applyStimulus(0, 1, 8'h21, 0);
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("rs_regwrite", {15'd0, REG_WRITE}, 16'h0000);
    checkOutput("rs_cmderr",   {15'd0, CMD_ERR},   16'h0000);
    checkOutput("rs_cmdcode",  {8'd0, CMD_CODE},   16'h0021);
    checkOutput("rs_busy_low", {15'd0, BUSY},      16'h0000);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("rs_events", 16'((wrCount - wr0) + (errCount - er0)), 16'h0000);

    // Last data byte arriving together with STOP still counts.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h21, 0);
    applyStimulus(0, 1, 8'h34, 0);
    applyStimulus(0, 1, 8'h12, 1);
    checkOutput("vs_regwrite", {15'd0, REG_WRITE}, 16'h0001);
    checkOutput("vs_cmderr",   {15'd0, CMD_ERR},   16'h0000);
    checkOutput("vs_data",     DATA_OUT,           16'h1234);
    applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("vs_data_hold", DATA_OUT, 16'h1234);

    // STOP and START together: the write completes and a new transaction begins.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h40, 0);
    applyStimulus(0, 1, 8'h11, 0);
    applyStimulus(0, 1, 8'h22, 0);
    applyStimulus(1, 0, 8'h00, 1);
    checkOutput("ss_regwrite", {15'd0, REG_WRITE}, 16'h0001);
    checkOutput("ss_data",     DATA_OUT,           16'h2211);
    checkOutput("ss_busy",     {15'd0, BUSY},      16'h0001);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("ss_quick_wr",  {15'd0, REG_WRITE}, 16'h0000);
    checkOutput("ss_quick_err", {15'd0, CMD_ERR},   16'h0000);
    checkOutput("ss_quick_busy", {15'd0, BUSY},     16'h0000);

    // Asynchronous reset in the middle of a transaction.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h40, 0);
    applyStimulus(0, 1, 8'hAA, 0);
    RESET_N = 1'b0;
    #1;
    checkOutput("mr_regwrite", {15'd0, REG_WRITE}, 16'h0000);
    checkOutput("mr_cmdcode",  {8'd0, CMD_CODE},   16'h0000);
    checkOutput("mr_data",     DATA_OUT,           16'h0000);
    checkOutput("mr_cmderr",   {15'd0, CMD_ERR},   16'h0000);
    checkOutput("mr_busy",     {15'd0, BUSY},      16'h0000);
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    wr0 = wrCount;
    er0 = errCount;
    applyStimulus(0, 1, 8'hAA, 0);
    applyStimulus(0, 1, 8'h55, 1);
    checkOutput("idle_cmdcode", {8'd0, CMD_CODE}, 16'h0000);
    checkOutput("idle_busy",    {15'd0, BUSY},    16'h0000);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("idle_events", 16'((wrCount - wr0) + (errCount - er0)), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
